// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: walks one instruction through
// FETCH/DECODE/EXEC/MEM/WB over a single unified memory port.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             flag_write,
  input  logic             take_branch,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             rf_write_en,
  output logic             flag_write_en,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // wait counter only has to reach MEM_TIMEOUT-1
  localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_t             state_q, state_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               lat_mem_read_q, lat_mem_read_d;
  logic               lat_mem_write_q, lat_mem_write_d;
  logic               lat_reg_write_q, lat_reg_write_d;
  logic               lat_flag_write_q, lat_flag_write_d;
  logic               lat_take_branch_q, lat_take_branch_d;
  logic               retire;
  logic               stall_expired;

  assign stall_expired = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_FETCH;
      error_q           <= 1'b0;
      cnt_q             <= '0;
      wait_q            <= '0;
      lat_mem_read_q    <= 1'b0;
      lat_mem_write_q   <= 1'b0;
      lat_reg_write_q   <= 1'b0;
      lat_flag_write_q  <= 1'b0;
      lat_take_branch_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      error_q           <= error_d;
      cnt_q             <= cnt_d;
      wait_q            <= wait_d;
      lat_mem_read_q    <= lat_mem_read_d;
      lat_mem_write_q   <= lat_mem_write_d;
      lat_reg_write_q   <= lat_reg_write_d;
      lat_flag_write_q  <= lat_flag_write_d;
      lat_take_branch_q <= lat_take_branch_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    error_d           = error_q;
    cnt_d             = cnt_q;
    lat_mem_read_d    = lat_mem_read_q;
    lat_mem_write_d   = lat_mem_write_q;
    lat_reg_write_d   = lat_reg_write_q;
    lat_flag_write_d  = lat_flag_write_q;
    lat_take_branch_d = lat_take_branch_q;
    retire            = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    addr_sel          = 1'b0;
    ir_write          = 1'b0;
    mdr_write         = 1'b0;
    rf_write_en       = 1'b0;
    flag_write_en     = 1'b0;
    pc_write          = 1'b0;
    pc_sel            = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (stall_expired) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end
      end
      S_DECODE: begin
        lat_mem_read_d    = mem_read;
        lat_mem_write_d   = mem_write;
        lat_reg_write_d   = reg_write;
        lat_flag_write_d  = flag_write;
        lat_take_branch_d = take_branch;
        state_d           = S_EXEC;
      end
      S_EXEC: begin
        flag_write_en = lat_flag_write_q;
        if (lat_mem_read_q || lat_mem_write_q) begin
          state_d = S_MEM;
        end else if (lat_reg_write_q) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = lat_mem_write_q;
        if (mem_ready) begin
          // a write access always finishes the instruction here
          if (lat_mem_write_q) begin
            retire = 1'b1;
          end else begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else if (stall_expired) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end
      end
      S_WB: begin
        rf_write_en = 1'b1;
        retire      = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      pc_write = 1'b1;
      pc_sel   = lat_take_branch_q;
      cnt_d    = cnt_q + CNT_W'(1);
      state_d  = halt_req ? S_HALT : S_FETCH;
    end

    if (mem_ready || (state_d != state_q)) begin
      wait_d = '0;
    end else if (mem_req) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  assign state       = state_q;
  assign error       = error_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: each instruction is expanded into
// an expected per-cycle schedule from its class and memory wait counts.
module tb_multicycle_sequencer;
  localparam int TO = 4;
  localparam int CW = 8;

  localparam logic [8:0] EN_REQ  = 9'h100;
  localparam logic [8:0] EN_WE   = 9'h080;
  localparam logic [8:0] EN_ADDR = 9'h040;
  localparam logic [8:0] EN_IR   = 9'h020;
  localparam logic [8:0] EN_MDR  = 9'h010;
  localparam logic [8:0] EN_RF   = 9'h008;
  localparam logic [8:0] EN_FL   = 9'h004;
  localparam logic [8:0] EN_PC   = 9'h002;
  localparam logic [8:0] EN_SEL  = 9'h001;

  // instruction classes: 0 ALU, 1 LDUR, 2 STUR, 3 B/CBZ, 4 BL
  typedef struct {
    logic [2:0] st;
    logic [8:0] en;
    logic       rdy;
    logic       last;
  } cyc_t;

  logic clk = 1'b0;
  logic reset, mem_read, mem_write, reg_write, flag_write, take_branch, halt_req, mem_ready;
  logic mem_req, mem_we, addr_sel, ir_write, mdr_write, rf_write_en, flag_write_en, pc_write, pc_sel;
  logic [2:0]    state;
  logic          error;
  logic [CW-1:0] instr_count;
  logic [8:0]    en_obs;

  int n_checks  = 0;
  int n_errors  = 0;
  int model_cnt = 0;
  bit model_err = 1'b0;
  int n_instr   = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .flag_write(flag_write), .take_branch(take_branch),
    .halt_req(halt_req), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .mdr_write(mdr_write),
    .rf_write_en(rf_write_en), .flag_write_en(flag_write_en), .pc_write(pc_write),
    .pc_sel(pc_sel), .state(state), .error(error), .instr_count(instr_count)
  );

  assign en_obs = {mem_req, mem_we, addr_sel, ir_write, mdr_write,
                   rf_write_en, flag_write_en, pc_write, pc_sel};

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_inputs();
    mem_read    = rbit();
    mem_write   = rbit();
    reg_write   = rbit();
    flag_write  = rbit();
    take_branch = rbit();
    halt_req    = rbit();
    mem_ready   = rbit();
  endtask

  // compare one cycle at the falling edge, then advance past the rising edge
  task automatic sample(input logic [2:0] st, input logic [8:0] en, input string tag);
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".en"},    32'(en_obs), 32'(en));
    check({tag, ".error"}, 32'(error), 32'(model_err));
    check({tag, ".count"}, 32'(instr_count), 32'(model_cnt % (1 << CW)));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rand_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    model_cnt = 0;
    model_err = 1'b0;
  endtask

  // abort_at: -1 none, -2 random cycle, else cycle index at which reset is pulsed
  task automatic run_instr(input int kind, input bit fw, input bit tb, input int wf,
                           input int wm, input bit halt_last, input int abort_at);
    cyc_t  q[$];
    cyc_t  c;
    bit    mr, mw, rw, timed_out, halted;
    int    ab;
    string tag;
    mr = (kind == 1);
    mw = (kind == 2);
    rw = (kind == 0) || (kind == 1) || (kind == 4);
    timed_out = 1'b0;
    n_instr++;

    for (int i = 0; i <= wf && i < TO; i++) begin
      c.st = 3'd0; c.rdy = (i == wf); c.last = 1'b0;
      c.en = EN_REQ | (c.rdy ? EN_IR : 9'h0);
      q.push_back(c);
    end
    if (wf >= TO) timed_out = 1'b1;
    if (!timed_out) begin
      c.st = 3'd1; c.en = 9'h0; c.rdy = rbit(); c.last = 1'b0;
      q.push_back(c);
      c.st = 3'd2; c.rdy = rbit(); c.en = fw ? EN_FL : 9'h0;
      c.last = !mr && !mw && !rw;
      if (c.last) c.en = c.en | EN_PC | (tb ? EN_SEL : 9'h0);
      q.push_back(c);
      if (mr || mw) begin
        for (int i = 0; i <= wm && i < TO; i++) begin
          c.st = 3'd3; c.rdy = (i == wm);
          c.en = EN_REQ | EN_ADDR | (mw ? EN_WE : 9'h0);
          c.last = c.rdy && mw;
          if (c.rdy) c.en = c.en | (mw ? (EN_PC | (tb ? EN_SEL : 9'h0)) : EN_MDR);
          q.push_back(c);
        end
        if (wm >= TO) timed_out = 1'b1;
      end
      if (!timed_out && (mr || (!mw && rw))) begin
        c.st = 3'd4; c.rdy = rbit(); c.last = 1'b1;
        c.en = EN_RF | EN_PC | (tb ? EN_SEL : 9'h0);
        q.push_back(c);
      end
    end

    ab = abort_at;
    if (ab == -2) ab = (q.size() > 1) ? int'($urandom_range(1, q.size() - 1)) : -1;

    for (int i = 0; i < q.size(); i++) begin
      if (i == ab) begin
        pulse_reset();
        return;
      end
      rand_inputs();
      reset = 1'b0;
      if (q[i].st == 3'd0 || q[i].st == 3'd3) mem_ready = q[i].rdy;
      halt_req = q[i].last ? halt_last : rbit();
      if (q[i].st == 3'd1) begin
        mem_read = mr; mem_write = mw; reg_write = rw; flag_write = fw; take_branch = tb;
      end
      tag = $sformatf("i%0d.k%0d.c%0d", n_instr, kind, i);
      sample(q[i].st, q[i].en, tag);
      if (q[i].last) model_cnt++;
    end

    halted = timed_out || halt_last;
    if (timed_out) model_err = 1'b1;
    if (halted) begin
      for (int i = 0; i < 3; i++) begin
        rand_inputs();
        sample(3'd5, 9'h0, $sformatf("i%0d.halt%0d", n_instr, i));
      end
      pulse_reset();
    end
  endtask

  function automatic int rand_wait(input bit allow_timeout);
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 0;
    if (r <= 7) return int'($urandom_range(1, 2));
    if (r == 8 || !allow_timeout) return TO - 1;
    return TO;
  endfunction

  initial begin
    rand_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(0, 1, 0, 0, 0, 0, -1);   // ADDS
    run_instr(1, 0, 0, 0, 3, 0, -1);   // LDUR with 3 wait cycles
    run_instr(2, 0, 0, 0, 0, 0, -1);   // STUR
    run_instr(3, 0, 1, 0, 0, 0, -1);   // B
    run_instr(4, 0, 1, 1, 0, 0, -1);   // BL
    run_instr(0, 0, 0, TO, 0, 0, -1);  // fetch timeout
    run_instr(0, 1, 0, TO - 1, 0, 0, -1); // ready on the last allowed cycle
    run_instr(2, 1, 0, 0, TO, 0, -1);  // store timeout in MEM
    run_instr(1, 0, 1, 0, TO - 1, 0, -1);
    run_instr(0, 1, 0, 0, 0, 1, -1);   // halt after ADDS
    run_instr(3, 0, 0, 0, 0, 0, -1);
    run_instr(0, 1, 1, 0, 0, 0, 2);    // reset mid-EXEC

    for (int n = 0; n < 300; n++)
      run_instr(int'($urandom_range(0, 4)), rbit(), rbit(), rand_wait(0), rand_wait(0), 1'b0, -1);

    for (int n = 0; n < 250; n++)
      run_instr(int'($urandom_range(0, 4)), rbit(), rbit(), rand_wait(1), rand_wait(1),
                ($urandom_range(0, 11) == 0), ($urandom_range(0, 14) == 0) ? -2 : -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle LEGv8 sequencer.
- Steps one instruction through FETCH, DECODE, EXEC, MEM and WB states over a single shared unified memory port.
- Takes decoded control fields from the instruction decoder as inputs and produces the per-cycle enables for the PC, IR, MDR, register file, flags and memory.
- Also provides a memory-wait timeout, a halt request, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready memory cycles before the error halt; 0 disables the timeout.
CNT_W, 32, width of instr_count.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
mem_read  input  1  decoded load
mem_write  input  1  decoded store
reg_write  input  1  decoded register-file write
flag_write  input  1  decoded flag update
take_branch  input  1  decoder/branch logic: PC takes the branch target
halt_req  input  1  request a stop at the next instruction boundary
mem_ready  input  1  unified memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  1 = write (store); valid only when mem_req=1
addr_sel  output  1  0 = PC, 1 = ALU result drives the memory address
ir_write  output  1  load IR from memory read data
mdr_write  output  1  load MDR from memory read data
rf_write_en  output  1  register-file write enable
flag_write_en  output  1  flag register write enable
pc_write  output  1  update PC; asserted once per retired instruction
pc_sel  output  1  0 = PC+4, 1 = branch target
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
error  output  1  sticky memory-timeout flag
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- All registers update on the clk rising edge. Reset is synchronous and active-high, takes priority, and acts mid-instruction.
- Reset values: state=FETCH, error=0, instr_count=0, wait_cnt=0, latched controls=0.
- All enables and mem_req are combinational from state, latched controls and mem_ready. They are 0 in any state not listed below.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - If mem_ready: ir_write=1, next state DECODE.
- DECODE:
  - Latch mem_read, mem_write, reg_write, flag_write and take_branch into internal registers. These latched values are the only source of control used in EXEC, MEM and WB.
  - Next state EXEC.
- EXEC:
  - flag_write_en = latched flag_write.
  - If latched mem_read or mem_write: next state MEM.
  - Else if latched reg_write: next state WB. This covers ALU ops and BL.
  - Else: last cycle of the instruction (B, BR, CBZ, B.LT, no-op).
- MEM:
  - mem_req=1, addr_sel=1, mem_we = latched mem_write.
  - On mem_ready with a load: mdr_write=1, next state WB.
  - On mem_ready with a store: last cycle of the instruction.
- WB: rf_write_en=1; last cycle of the instruction.
- Last cycle of an instruction:
  - pc_write=1, pc_sel = latched take_branch, instr_count increments by 1 (wraps modulo 2^CNT_W).
  - Next state is HALT if halt_req=1 in that cycle, else FETCH.
- halt_req asserted in any other cycle is ignored. It must be held by the requester until honoured.
- Timeout:
  - wait_cnt increments each cycle with mem_req=1 and mem_ready=0.
  - wait_cnt clears on mem_ready and on every state change.
  - With MEM_TIMEOUT>0, if wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: next state HALT and error becomes 1. No pc_write and no count occur.
  - If mem_ready arrives in the same cycle as the timeout condition, ready wins and the access completes normally.
- HALT: all enables 0, mem_req=0. The block stays in HALT until reset; error holds its value.
- Latency with zero-wait memory, including the pc_write cycle:
  - ALU op: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - B/CBZ: 3 cycles.
  - BL: 4 cycles.
- Each memory wait cycle adds 1 cycle.

Test Plan:
- Reset, then ADDS (reg_write=1, flag_write=1) with mem_ready=1 → states 0,1,2,4. flag_write_en=1 in EXEC. rf_write_en=1, pc_write=1 and pc_sel=0 in WB. instr_count=1 after 4 cycles.
- LDUR with mem_ready low for 3 MEM cycles → states 0,1,2,3,3,3,3,4. mem_we=0 and addr_sel=1 in MEM. mdr_write=1 only on the ready cycle. Total 8 cycles.
- STUR then B (take_branch=1) → STUR: mem_we=1 in MEM and pc_write in MEM, 4 cycles. B: pc_write=1, pc_sel=1 in EXEC, 3 cycles. instr_count=2.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → after 4 FETCH cycles state=5 and error=1. pc_write is never asserted. Outputs stay idle until reset, then state=0 and error=0.
- mem_ready rising exactly on the 4th wait cycle with MEM_TIMEOUT=4 → ir_write=1, state goes to DECODE, error=0.
- halt_req=1 during DECODE of an ADDS, held → the instruction retires (instr_count +1), then state=5. A reset pulse mid-EXEC returns the block to FETCH with instr_count=0.
